// File: rtl/fan_pipe.sv
// fan_pipe: pipelined add/subtract. Each stage resolves k bits of the sum with a ripple chain.
// Valid/ready on both sides, with a combinational ready chain so occupancy never needs a skid buffer.
module fan_pipe #(
    parameter int unsigned n = 8,
    parameter int unsigned k = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] s,
    output logic         cout,
    output logic         ovf
);
    localparam int unsigned p = n / k;

    logic [p-1:0] vld_q, vld_d;
    logic [n-1:0] a_q [p];
    logic [n-1:0] a_d [p];
    logic [n-1:0] b_q [p];
    logic [n-1:0] b_d [p];
    logic [n-1:0] s_q [p];
    logic [n-1:0] s_d [p];
    logic [p-1:0] c_q, c_d;
    logic         cm_q, cm_d;

    // go[j]: stage j may load this cycle; go[p] is the downstream acceptance.
    logic [p:0]   go;

    logic [p-1:0] in_vld;
    logic [n-1:0] in_a [p];
    logic [n-1:0] in_b [p];
    logic [n-1:0] in_s [p];
    logic [p-1:0] in_c;

    logic [n-1:0] rs;
    logic         rc;
    logic         rm;

    always_comb begin
        go[p] = out_ready;
        for (int j = int'(p) - 1; j >= 0; j--) begin
            go[j] = !vld_q[j] || go[j+1];
        end
    end

    assign in_ready = go[0] && !rst;

    // Stage 0 sees the conditioned operands; later stages see the previous stage register.
    always_comb begin
        in_vld[0] = in_valid && in_ready;
        in_a[0]   = a;
        in_b[0]   = sub ? ~b : b;
        in_s[0]   = '0;
        in_c[0]   = sub ? ~cin : cin;
        for (int j = 1; j < int'(p); j++) begin
            in_vld[j] = vld_q[j-1];
            in_a[j]   = a_q[j-1];
            in_b[j]   = b_q[j-1];
            in_s[j]   = s_q[j-1];
            in_c[j]   = c_q[j-1];
        end
    end

    always_comb begin
        vld_d = vld_q;
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
        c_d   = c_q;
        cm_d  = cm_q;
        rs    = '0;
        rc    = 1'b0;
        rm    = 1'b0;
        for (int j = 0; j < int'(p); j++) begin
            rs = in_s[j];
            rc = in_c[j];
            for (int i = 0; i < int'(k); i++) begin
                rs[j*int'(k)+i] = in_a[j][j*int'(k)+i] ^ in_b[j][j*int'(k)+i] ^ rc;
                if (j * int'(k) + i == int'(n) - 1) begin
                    rm = rc;
                end
                rc = (in_a[j][j*int'(k)+i] & in_b[j][j*int'(k)+i])
                   | (rc & (in_a[j][j*int'(k)+i] ^ in_b[j][j*int'(k)+i]));
            end
            if (go[j]) begin
                vld_d[j] = in_vld[j];
            end
            // Data only moves with a real operation, so outputs never toggle under bubbles.
            if (go[j] && in_vld[j]) begin
                a_d[j] = in_a[j];
                b_d[j] = in_b[j];
                s_d[j] = rs;
                c_d[j] = rc;
                if (j == int'(p) - 1) begin
                    cm_d = rm;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            c_q   <= '0;
            cm_q  <= 1'b0;
            for (int j = 0; j < int'(p); j++) begin
                a_q[j] <= '0;
                b_q[j] <= '0;
                s_q[j] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            cm_q  <= cm_d;
        end
    end

    assign out_valid = vld_q[p-1];
    assign s         = s_q[p-1];
    assign cout      = c_q[p-1];
    assign ovf       = cm_q ^ c_q[p-1];

endmodule

// File: tb/tb_fan_pipe.sv
// Directed and randomised checks of fan_pipe for (n,k) = (8,4), (32,8) and (8,8).
module tb_fan_pipe;
    localparam int NOPS  = 10000;
    localparam int LIMIT = 40000;

    logic clk;
    logic rst;

    logic       x_in_valid, x_in_ready, x_out_valid, x_out_ready, x_cin, x_sub, x_cout, x_ovf;
    logic [7:0] x_a, x_b, x_s;
    logic        y_in_valid, y_in_ready, y_out_valid, y_out_ready, y_cin, y_sub, y_cout, y_ovf;
    logic [31:0] y_a, y_b, y_s;
    logic       z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_cin, z_sub, z_cout, z_ovf;
    logic [7:0] z_a, z_b, z_s;

    int total = 0;
    int bad   = 0;

    fan_pipe #(.n(8), .k(4)) u_x (
        .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_ready(x_in_ready), .a(x_a), .b(x_b),
        .cin(x_cin), .sub(x_sub), .out_valid(x_out_valid), .out_ready(x_out_ready), .s(x_s),
        .cout(x_cout), .ovf(x_ovf)
    );

    fan_pipe #(.n(32), .k(8)) u_y (
        .clk(clk), .rst(rst), .in_valid(y_in_valid), .in_ready(y_in_ready), .a(y_a), .b(y_b),
        .cin(y_cin), .sub(y_sub), .out_valid(y_out_valid), .out_ready(y_out_ready), .s(y_s),
        .cout(y_cout), .ovf(y_ovf)
    );

    fan_pipe #(.n(8), .k(8)) u_z (
        .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready), .a(z_a), .b(z_b),
        .cin(z_cin), .sub(z_sub), .out_valid(z_out_valid), .out_ready(z_out_ready), .s(z_s),
        .cout(z_cout), .ovf(z_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Golden model: {ovf, cout, s} packed as s in [w-1:0], cout at w, ovf at w+1.
    function automatic logic [63:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                          input logic ci, input logic sb);
        logic [63:0] mask, yb, full, sm;
        logic        c0, co, ov;
        mask = (64'd1 << w) - 64'd1;
        yb   = sb ? (~y & mask) : y;
        c0   = sb ? ~ci : ci;
        full = x + yb + {63'd0, c0};
        sm   = full & mask;
        co   = full[w];
        ov   = (x[w-1] == yb[w-1]) && (sm[w-1] != x[w-1]);
        return sm | ({63'd0, co} << w) | ({63'd0, ov} << (w + 1));
    endfunction

    function automatic logic [63:0] x_obs();
        return {54'd0, x_ovf, x_cout, x_s};
    endfunction

    task automatic drive_x(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                           input logic ts);
        x_in_valid = 1'b1;
        x_a        = ta;
        x_b        = tb;
        x_cin      = tc;
        x_sub      = ts;
    endtask

    // Called just after a rising edge; checks the 2-cycle latency and the result.
    task automatic run_one(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                           input logic tc, input logic ts, input logic [9:0] exp);
        drive_x(ta, tb, tc, ts);
        @(negedge clk);
        check({tag, "_rdy"}, 64'(x_in_ready), 64'd1);
        @(posedge clk);
        #1;
        x_in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_early"}, 64'(x_out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_vld"}, 64'(x_out_valid), 64'd1);
        check({tag, "_res"}, x_obs(), 64'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic rand_y();
        logic [63:0] q[$];
        logic [63:0] exp;
        int          sent = 0;
        int          cyc  = 0;
        logic        acc;
        while ((sent < NOPS || q.size() != 0) && cyc < LIMIT) begin
            @(negedge clk);
            acc = y_in_valid && y_in_ready;
            if (y_out_valid && y_out_ready) begin
                exp = (q.size() != 0) ? q.pop_front() : '1;
                check("y_res", {30'd0, y_ovf, y_cout, y_s}, exp);
            end
            if (acc) begin
                q.push_back(model(32, 64'(y_a), 64'(y_b), y_cin, y_sub));
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc || !y_in_valid) begin
                y_in_valid = (sent < NOPS) && ($urandom_range(0, 3) != 0);
                y_a        = $urandom();
                y_b        = $urandom();
                y_cin      = 1'($urandom_range(0, 1));
                y_sub      = 1'($urandom_range(0, 1));
            end
            y_out_ready = (sent >= NOPS) || ($urandom_range(0, 3) != 0);
            cyc++;
        end
        check("y_left", 64'(NOPS - sent + q.size()), 64'd0);
    endtask

    task automatic rand_z();
        logic [63:0] q[$];
        logic [63:0] exp;
        int          sent = 0;
        int          cyc  = 0;
        logic        acc;
        while ((sent < NOPS || q.size() != 0) && cyc < LIMIT) begin
            @(negedge clk);
            acc = z_in_valid && z_in_ready;
            if (z_out_valid && z_out_ready) begin
                exp = (q.size() != 0) ? q.pop_front() : '1;
                check("z_res", {54'd0, z_ovf, z_cout, z_s}, exp);
            end
            if (acc) begin
                q.push_back(model(8, 64'(z_a), 64'(z_b), z_cin, z_sub));
                sent++;
            end
            @(posedge clk);
            #1;
            if (acc || !z_in_valid) begin
                z_in_valid = (sent < NOPS) && ($urandom_range(0, 3) != 0);
                z_a        = 8'($urandom());
                z_b        = 8'($urandom());
                z_cin      = 1'($urandom_range(0, 1));
                z_sub      = 1'($urandom_range(0, 1));
            end
            z_out_ready = (sent >= NOPS) || ($urandom_range(0, 3) != 0);
            cyc++;
        end
        check("z_left", 64'(NOPS - sent + q.size()), 64'd0);
    endtask

    logic [7:0] bp_a   [5] = '{8'h01, 8'h40, 8'hF0, 8'h05, 8'h80};
    logic [7:0] bp_b   [5] = '{8'h02, 8'h40, 8'h20, 8'h03, 8'h7F};
    logic       bp_c   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       bp_s   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [9:0] bp_exp [5] = '{10'h003, 10'h280, 10'h111, 10'h102, 10'h300};

    initial begin
        int   snd;
        int   rcv;
        int   cyc;
        logic acc;

        rst         = 1'b1;
        x_in_valid  = 1'b0;
        x_out_ready = 1'b1;
        x_a = '0; x_b = '0; x_cin = 1'b0; x_sub = 1'b0;
        y_in_valid  = 1'b0;
        y_out_ready = 1'b1;
        y_a = '0; y_b = '0; y_cin = 1'b0; y_sub = 1'b0;
        z_in_valid  = 1'b0;
        z_out_ready = 1'b1;
        z_a = '0; z_b = '0; z_cin = 1'b0; z_sub = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld", 64'(x_out_valid), 64'd0);
        check("rst_res", x_obs(), 64'd0);
        check("rst_rdy", 64'(x_in_ready), 64'd0);
        check("rst_vld_y", 64'(y_out_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", 64'(x_in_ready), 64'd1);
        @(posedge clk);
        #1;

        run_one("add_ovf", 8'h3C, 8'h47, 1'b0, 1'b0, 10'h283);
        run_one("sub_brw", 8'h10, 8'h20, 1'b1, 1'b1, 10'h0EF);
        run_one("ripple", 8'hFF, 8'h00, 1'b1, 1'b0, 10'h100);
        run_one("pos_ovf", 8'h7F, 8'h01, 1'b0, 1'b0, 10'h280);
        run_one("neg_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 10'h37F);
        run_one("wrap", 8'hFF, 8'hFF, 1'b1, 1'b0, 10'h1FF);

        // Backpressure: fill the two stages with the output held off.
        x_out_ready = 1'b0;
        drive_x(bp_a[0], bp_b[0], bp_c[0], bp_s[0]);
        @(negedge clk);
        check("bp_rdy0", 64'(x_in_ready), 64'd1);
        @(posedge clk);
        #1;
        drive_x(bp_a[1], bp_b[1], bp_c[1], bp_s[1]);
        @(negedge clk);
        check("bp_rdy1", 64'(x_in_ready), 64'd1);
        @(posedge clk);
        #1;
        drive_x(bp_a[2], bp_b[2], bp_c[2], bp_s[2]);
        repeat (3) begin
            @(negedge clk);
            check("bp_full_rdy", 64'(x_in_ready), 64'd0);
            check("bp_hold_vld", 64'(x_out_valid), 64'd1);
            check("bp_hold_res", x_obs(), 64'(bp_exp[0]));
        end
        @(posedge clk);
        #1;
        x_out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 64'(x_in_ready), 64'd1);
        snd = 2;
        rcv = 0;
        cyc = 0;
        while (rcv < 5 && cyc < 40) begin
            @(negedge clk);
            acc = x_in_valid && x_in_ready;
            if (x_out_valid) begin
                check("bp_res", x_obs(), 64'(bp_exp[rcv]));
                rcv++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                snd++;
                if (snd < 5) drive_x(bp_a[snd], bp_b[snd], bp_c[snd], bp_s[snd]);
                else x_in_valid = 1'b0;
            end
            cyc++;
        end
        check("bp_count", 64'(rcv), 64'd5);

        // Reset with two operations in flight; neither may surface afterwards.
        x_out_ready = 1'b0;
        drive_x(8'h11, 8'h11, 1'b0, 1'b0);
        @(negedge clk);
        check("mr_rdy0", 64'(x_in_ready), 64'd1);
        @(posedge clk);
        #1;
        drive_x(8'h33, 8'h33, 1'b0, 1'b0);
        @(negedge clk);
        check("mr_rdy1", 64'(x_in_ready), 64'd1);
        @(posedge clk);
        #1;
        x_in_valid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        check("mr_rst_rdy", 64'(x_in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst         = 1'b0;
        x_out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("mr_idle_vld", 64'(x_out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        run_one("mr_new", 8'h01, 8'h01, 1'b0, 1'b0, 10'h002);

        fork
            rand_y();
            rand_z();
        join

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
